// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between the CPU control FSM and a program loader.
// Optional loader anti-starvation preemption is enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_stall,
  input  logic       ldr_req,
  input  logic       ldr_we,
  input  logic [4:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  output logic       ldr_ack,
  output logic [7:0] ldr_rdata,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [4:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       gnt_ldr
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CPU, LDR, LDR_ACK} state_t;

  state_t state, state_nxt;
  logic   cpu_req;
  logic   preempt;

  assign cpu_req = cpu_rd | cpu_wr;

`ifdef MEM_ARB_STARVE_EN
  logic [3:0] wait_cnt;

  // Counts cycles the loader has been waiting behind the CPU; saturates at 15.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (state == LDR || !ldr_req) begin
      wait_cnt <= 4'd0;
    end else if (state == CPU && wait_cnt != 4'hF) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  assign preempt = (state == CPU) && ldr_req && (wait_cnt >= STARVE_LIM);
`else
  logic unused_starve;
  assign unused_starve = ^STARVE_LIM;
  assign preempt       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and bus steering; the CPU owns the bus unless the loader is granted.
  always_comb begin
    state_nxt = state;
    mem_rd    = cpu_rd & ~cpu_wr;
    mem_wr    = cpu_wr;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    ldr_ack   = 1'b0;
    gnt_ldr   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req)      state_nxt = CPU;
        else if (ldr_req) state_nxt = LDR;
      end
      CPU: begin
        if (preempt)                 state_nxt = LDR;
        else if (!cpu_req && ldr_req) state_nxt = LDR;
        else if (!cpu_req)            state_nxt = IDLE;
      end
      LDR: begin
        gnt_ldr   = 1'b1;
        mem_rd    = ~ldr_we;
        mem_wr    = ldr_we;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        state_nxt = LDR_ACK;
      end
      LDR_ACK: begin
        gnt_ldr   = 1'b1;
        ldr_ack   = 1'b1;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        state_nxt = cpu_req ? CPU : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cpu_stall = cpu_req & gnt_ldr;
  assign cpu_rdata = mem_rdata;

  // Loader read data is captured as the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ldr_rdata <= 8'h00;
    else if (state == LDR && !ldr_we) ldr_rdata <= mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural memory behind the memory port.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [4:0] cpu_addr = 5'd0;
  logic [7:0] cpu_wdata = 8'd0;
  logic [7:0] cpu_rdata;
  logic       cpu_stall;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [4:0] ldr_addr = 5'd0;
  logic [7:0] ldr_wdata = 8'd0;
  logic       ldr_ack;
  logic [7:0] ldr_rdata;
  logic       mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       gnt_ldr;

  logic [7:0] mem [32];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt_ldr(gnt_ldr)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int gnt_seen;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    mem[3] = 8'h3C;

    // Reset asserted mid-cycle
    #3;
    check("rst_gnt", 32'(gnt_ldr), 32'd0);
    check("rst_ack", 32'(ldr_ack), 32'd0);
    check("rst_rdata", 32'(ldr_rdata), 32'h00);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    #10 rst_n = 1'b1;
    step();

    // Loader write with the CPU quiet
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'h1F; ldr_wdata = 8'hA5;
    #1;
    check("w_idle_memwr", 32'(mem_wr), 32'd0);
    step();
    check("w_ldr_gnt", 32'(gnt_ldr), 32'd1);
    check("w_ldr_memwr", 32'(mem_wr), 32'd1);
    check("w_ldr_memrd", 32'(mem_rd), 32'd0);
    check("w_ldr_addr", 32'(mem_addr), 32'h1F);
    check("w_ldr_wdata", 32'(mem_wdata), 32'hA5);
    check("w_ldr_ack", 32'(ldr_ack), 32'd0);
    check("w_ldr_stall", 32'(cpu_stall), 32'd0);
    step();
    check("w_ack", 32'(ldr_ack), 32'd1);
    check("w_ack_memwr", 32'(mem_wr), 32'd0);
    check("w_ack_stall", 32'(cpu_stall), 32'd0);
    ldr_req = 1'b0;
    step();
    check("w_done_ack", 32'(ldr_ack), 32'd0);
    check("w_done_gnt", 32'(gnt_ldr), 32'd0);
    check("w_mem31", 32'(mem[31]), 32'hA5);

    // Loader read of address 3
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'd3;
    step();
    check("r_ldr_memrd", 32'(mem_rd), 32'd1);
    check("r_ldr_addr", 32'(mem_addr), 32'd3);
    step();
    check("r_ack", 32'(ldr_ack), 32'd1);
    check("r_rdata", 32'(ldr_rdata), 32'h3C);
    ldr_req = 1'b0;
    cpu_rd = 1'b1; cpu_addr = 5'h1F;
    #1;
    check("r_ack_cpu_stall", 32'(cpu_stall), 32'd1);
    step();
    check("r_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    check("r_rdata_held", 32'(ldr_rdata), 32'h3C);
    cpu_rd = 1'b0;
    step();

    // Same-cycle tie in IDLE: CPU first, loader after cpu_rd drops
    cpu_rd = 1'b1; cpu_addr = 5'd3;
    ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 5'd7; ldr_wdata = 8'h5A;
    step();
    check("tie_gnt", 32'(gnt_ldr), 32'd0);
    check("tie_memrd", 32'(mem_rd), 32'd1);
    check("tie_addr", 32'(mem_addr), 32'd3);
    check("tie_cpu_rdata", 32'(cpu_rdata), 32'h3C);
    check("tie_stall", 32'(cpu_stall), 32'd0);
    step();
    check("tie_hold_gnt", 32'(gnt_ldr), 32'd0);
    cpu_rd = 1'b0;
    step();
    check("tie_ldr_gnt", 32'(gnt_ldr), 32'd1);
    check("tie_ldr_addr", 32'(mem_addr), 32'd7);
    check("tie_ldr_memwr", 32'(mem_wr), 32'd1);
    step();
    check("tie_ack", 32'(ldr_ack), 32'd1);
    ldr_req = 1'b0;
    step();
    check("tie_mem7", 32'(mem[7]), 32'h5A);
    check("tie_rdata_held", 32'(ldr_rdata), 32'h3C);

    // CPU holds the bus while the loader waits
    cpu_rd = 1'b1; cpu_addr = 5'd3;
    step();
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'h1F;
`ifdef MEM_ARB_STARVE_EN
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (gnt_ldr) begin
        k = c;
        break;
      end
    end
    check("starve_latency", 32'(k), 32'd5);
    check("starve_stall1", 32'(cpu_stall), 32'd1);
    check("starve_memrd_ldr", 32'(mem_addr), 32'h1F);
    step();
    check("starve_ack", 32'(ldr_ack), 32'd1);
    check("starve_stall2", 32'(cpu_stall), 32'd1);
    check("starve_rdata", 32'(ldr_rdata), 32'hA5);
    ldr_req = 1'b0;
    step();
    check("starve_back_gnt", 32'(gnt_ldr), 32'd0);
    check("starve_back_stall", 32'(cpu_stall), 32'd0);
    check("starve_back_addr", 32'(mem_addr), 32'd3);
    cpu_rd = 1'b0;
    step();
`else
    gnt_seen = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (gnt_ldr || cpu_stall) gnt_seen++;
    end
    check("strict_no_gnt", 32'(gnt_seen), 32'd0);
    check("strict_cpu_addr", 32'(mem_addr), 32'd3);
    cpu_rd = 1'b0;
    step();
    check("strict_ldr_gnt", 32'(gnt_ldr), 32'd1);
    check("strict_ldr_memrd", 32'(mem_rd), 32'd1);
    step();
    check("strict_ack", 32'(ldr_ack), 32'd1);
    check("strict_rdata", 32'(ldr_rdata), 32'hA5);
    ldr_req = 1'b0;
    step();
    check("strict_idle_gnt", 32'(gnt_ldr), 32'd0);
`endif

    // Reset arriving during a loader access aborts it
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 5'd7;
    step();
    check("abort_gnt_pre", 32'(gnt_ldr), 32'd1);
    #2 rst_n = 1'b0;
    ldr_req = 1'b0;
    cpu_wr = 1'b1; cpu_addr = 5'd2; cpu_wdata = 8'h11;
    #1;
    check("abort_gnt", 32'(gnt_ldr), 32'd0);
    check("abort_ack", 32'(ldr_ack), 32'd0);
    check("abort_rdata", 32'(ldr_rdata), 32'h00);
    check("abort_memwr", 32'(mem_wr), 32'd1);
    check("abort_addr", 32'(mem_addr), 32'd2);
    rst_n = 1'b1;
    step();
    check("abort_noack", 32'(ldr_ack), 32'd0);
    check("abort_mem2", 32'(mem[2]), 32'h11);
    cpu_wr = 1'b0;
    step();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
